// File: rtl/pdm_capture_if.sv
// Signal bundle between the PDM capture block and its consumer.
// The consumer side drives enable, micData and rd; the capture block drives the rest.
interface pdm_capture_if;
   logic        enable;
   logic        micData;
   logic        rd;
   logic        micLRSel;
   logic [15:0] dout;
   logic        done;
   logic        valid;
   logic        overrun;

   modport master (
      output enable, micData, rd,
      input  micLRSel, dout, done, valid, overrun
   );

   modport slave (
      input  enable, micData, rd,
      output micLRSel, dout, done, valid, overrun
   );
endinterface

// File: rtl/pdm_capture.sv
// PDM microphone capture: counts ones over DECIM-bit windows and publishes a
// saturated 16-bit PCM sample per window after a settling period.
module pdm_capture #(
   parameter int unsigned DECIM      = 128,
   parameter int unsigned SETTLE_WIN = 4
) (
   input logic         mclk,
   input logic         reset,
   pdm_capture_if.slave bus
);

   localparam int unsigned CntW = $clog2(DECIM);
   localparam int unsigned AccW = CntW + 1;
   localparam int unsigned SetW = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
   localparam logic [CntW-1:0] CntLast    = CntW'(DECIM - 1);
   localparam logic [SetW-1:0] SettleLast = SetW'((SETTLE_WIN == 0) ? 0 : SETTLE_WIN - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [SetW-1:0]   settle_q, settle_d;
   logic              s_q;
   logic [15:0]       dout_q, dout_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;

   logic              window_end;
   logic              publish;
   logic [AccW-1:0]   ones;
   logic signed [31:0] pcm_wide;
   logic [15:0]       pcm_sat;

   assign window_end = (cnt_q == CntLast);
   assign ones       = acc_q + AccW'(s_q);

   // (2*ones - DECIM) * 256, clamped to the signed 16-bit range
   always_comb begin
      pcm_wide = ($signed({{(32 - AccW){1'b0}}, ones}) * 2 - $signed(DECIM)) * 256;
      if (pcm_wide > 32'sd32767) begin
         pcm_sat = 16'h7fff;
      end else if (pcm_wide < -32'sd32768) begin
         pcm_sat = 16'h8000;
      end else begin
         pcm_sat = pcm_wide[15:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      settle_d  = settle_q;
      dout_d    = dout_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      publish   = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_d    = '0;
            acc_d    = '0;
            settle_d = '0;
            if (bus.enable) begin
               state_d   = (SETTLE_WIN == 0) ? StRun : StSettle;
               overrun_d = 1'b0;
            end
         end
         StSettle, StRun: begin
            if (!bus.enable) begin
               // partial window is dropped; held sample stays visible
               state_d  = StIdle;
               cnt_d    = '0;
               acc_d    = '0;
               settle_d = '0;
            end else if (window_end) begin
               cnt_d = '0;
               acc_d = '0;
               if (state_q == StSettle) begin
                  settle_d = settle_q + 1'b1;
                  if (settle_q == SettleLast) begin
                     state_d  = StRun;
                     settle_d = '0;
                  end
               end else begin
                  publish = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               acc_d = ones;
            end
         end
         default: state_d = StIdle;
      endcase

      if (publish) begin
         dout_d  = pcm_sat;
         done_d  = 1'b1;
         valid_d = 1'b1;
         if (valid_q && !bus.rd) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.rd) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         settle_q  <= '0;
         s_q       <= 1'b0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         settle_q  <= settle_d;
         s_q       <= bus.micData;
         dout_q    <= dout_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.micLRSel = 1'b0;
   assign bus.dout     = dout_q;
   assign bus.done     = done_q;
   assign bus.valid    = valid_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: directed scenarios plus randomized traffic, every cycle
// compared against a window/edge-count reference model.
module tb_pdm_capture;

   localparam int Decim     = 128;
   localparam int SettleWin = 4;

   logic mclk = 1'b0;
   logic reset;

   pdm_capture_if bus ();

   pdm_capture #(
      .DECIM      (Decim),
      .SETTLE_WIN (SettleWin)
   ) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 mclk = ~mclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: edges since enable, queue of captured bits per window
   bit          m_active = 0;
   int          m_k = 0;
   bit          m_q[$];
   logic [15:0] m_dout = '0;
   bit          m_done = 0;
   bit          m_valid = 0;
   bit          m_ovr = 0;
   bit          m_s = 0;

   function automatic logic [15:0] pcm(input int ones);
      int v;
      v = (2 * ones - Decim) * 256;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
   endfunction

   function automatic void model_step();
      bit pub;
      int ones;
      pub  = 0;
      ones = 0;
      if (reset) begin
         m_active = 0; m_k = 0; m_q.delete();
         m_dout = '0; m_done = 0; m_valid = 0; m_ovr = 0; m_s = 0;
         return;
      end
      if (!m_active) begin
         if (bus.enable) begin
            m_active = 1; m_k = 0; m_q.delete(); m_ovr = 0;
         end
      end else if (!bus.enable) begin
         m_active = 0;
      end else begin
         m_k++;
         m_q.push_back(m_s);
         if (m_q.size() == Decim) begin
            foreach (m_q[i]) ones += int'(m_q[i]);
            m_q.delete();
            if (m_k / Decim > SettleWin) pub = 1;
         end
      end
      if (pub) begin
         if (m_valid && !bus.rd) m_ovr = 1;
         m_valid = 1;
         m_dout  = pcm(ones);
      end else if (m_valid && bus.rd) begin
         m_valid = 0;
      end
      m_done = pub;
      m_s    = bus.micData;
   endfunction

   // Mic stimulus: 0 random density, 1 ones, 2 zeros, 3 alternating, 4 three-of-four
   int mic_mode = 2;
   int dens = 50;
   int idx = 0;

   task automatic drive_mic();
      if (idx % Decim == 0) dens = $urandom_range(0, 100);
      case (mic_mode)
         0: bus.micData = ($urandom_range(0, 99) < dens);
         1: bus.micData = 1'b1;
         2: bus.micData = 1'b0;
         3: bus.micData = idx[0];
         default: bus.micData = (idx % 4) != 0;
      endcase
   endtask

   task automatic tick();
      @(posedge mclk);
      model_step();
      #1;
      check_eq("dout", {16'h0, bus.dout}, {16'h0, m_dout});
      check_eq("done", {31'h0, bus.done}, {31'h0, m_done});
      check_eq("valid", {31'h0, bus.valid}, {31'h0, m_valid});
      check_eq("overrun", {31'h0, bus.overrun}, {31'h0, m_ovr});
      check_eq("micLRSel", {31'h0, bus.micLRSel}, 32'h0);
      idx++;
      drive_mic();
   endtask

   task automatic wait_done(input string tag, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.done && n < bound);
      if (!bus.done) check_eq({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   int          n;
   logic [15:0] saved;
   bit          held_ok;

   initial begin
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.rd      = 1'b0;
      bus.micData = 1'b0;
      repeat (3) tick();
      check_eq("rst_dout", {16'h0, bus.dout}, 32'h0);
      check_eq("rst_valid", {31'h0, bus.valid}, 32'h0);

      // All ones: latency and positive clamp
      reset      = 1'b0;
      mic_mode   = 1;
      bus.enable = 1'b1;
      tick();
      wait_done("ones", 700, n);
      check_eq("lat_ones", n, 640);
      check_eq("ones_dout", {16'h0, bus.dout}, 32'h7fff);
      check_eq("ones_valid", {31'h0, bus.valid}, 32'h1);
      check_eq("ones_ovr", {31'h0, bus.overrun}, 32'h0);

      // Unacknowledged second sample sets overrun; rd clears valid only
      wait_done("second", 200, n);
      check_eq("gap", n, 128);
      check_eq("ovr_set", {31'h0, bus.overrun}, 32'h1);
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      check_eq("rd_clr_valid", {31'h0, bus.valid}, 32'h0);
      tick();
      check_eq("ovr_sticky", {31'h0, bus.overrun}, 32'h1);

      // Re-enable clears overrun; rd coincident with publish
      bus.enable = 1'b0;
      tick();
      bus.enable = 1'b1;
      mic_mode   = 3;
      tick();
      check_eq("ovr_reen", {31'h0, bus.overrun}, 32'h0);
      wait_done("alt", 700, n);
      check_eq("lat_alt", n, 640);
      check_eq("alt_dout", {16'h0, bus.dout}, 32'h0);
      repeat (127) tick();
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      check_eq("same_done", {31'h0, bus.done}, 32'h1);
      check_eq("same_valid", {31'h0, bus.valid}, 32'h1);
      check_eq("same_ovr", {31'h0, bus.overrun}, 32'h0);

      mic_mode = 4;
      wait_done("p96a", 200, n);
      wait_done("p96b", 200, n);
      check_eq("p96_dout", {16'h0, bus.dout}, 32'h4000);

      mic_mode = 2;
      wait_done("zero_a", 200, n);
      wait_done("zero_b", 200, n);
      check_eq("zero_dout", {16'h0, bus.dout}, 32'h8000);

      // Drop enable mid-window, re-enter: full latency again, dout held
      repeat (50) tick();
      saved      = bus.dout;
      bus.enable = 1'b0;
      repeat (3) tick();
      bus.enable = 1'b1;
      mic_mode   = 1;
      tick();
      held_ok = 1;
      n = 0;
      while (n < 700) begin
         tick();
         n++;
         if (bus.done) break;
         if (bus.dout !== saved) held_ok = 0;
      end
      check_eq("reen_lat", n, 640);
      check_eq("reen_hold", {31'h0, held_ok}, 32'h1);
      check_eq("reen_dout", {16'h0, bus.dout}, 32'h7fff);

      // Reset mid-window in RUN
      repeat (30) tick();
      reset = 1'b1;
      tick();
      check_eq("mrst_dout", {16'h0, bus.dout}, 32'h0);
      check_eq("mrst_valid", {31'h0, bus.valid}, 32'h0);
      check_eq("mrst_done", {31'h0, bus.done}, 32'h0);
      reset = 1'b0;
      tick();
      wait_done("mrst", 700, n);
      check_eq("mrst_lat", n, 640);

      // Randomized traffic against the model
      mic_mode = 0;
      for (int i = 0; i < 12000; i++) begin
         if ($urandom_range(0, 2999) == 0) bus.enable = ~bus.enable;
         reset  = ($urandom_range(0, 4999) == 0);
         bus.rd = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 Parameter DECIM, default 128, meaning PDM bits per output sample (fixed, power of two).
REQ-002 Parameter SETTLE_WIN, default 4, meaning windows discarded after enable before samples are published.
REQ-003 mclk  input  1  microphone bit clock, also the block clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 enable  input  1  capture enable; low forces idle.
REQ-006 micData  input  1  PDM bit from MEMS microphone.
REQ-007 rd  input  1  consumer acknowledge of current sample.
REQ-008 micLRSel  output  1  microphone channel select, constant 0.
REQ-009 dout  output  16  signed two's-complement PCM sample.
REQ-010 done  output  1  one-cycle pulse when dout updates.
REQ-011 valid  output  1  level, high while an unacknowledged sample is held.
REQ-012 overrun  output  1  sticky flag, a sample was published while the previous one was unacknowledged.

Function
REQ-013 micData SHALL be registered once on every mclk edge into bit s; only s feeds the accumulator.
REQ-014 States SHALL be IDLE, SETTLE and RUN.
REQ-015 IDLE: bit counter cnt, accumulator acc and settle counter held at 0; no done.
REQ-016 IDLE->SETTLE on an edge with enable=1; overrun cleared on that edge; counting begins on the next edge.
REQ-017 In SETTLE/RUN, each edge: acc += s, cnt += 1; cnt width 7 bits for DECIM=128, acc 8 bits (range 0..128).
REQ-018 Window end is the edge with cnt==DECIM-1: ones = acc+s; acc<=0; cnt<=0 (wrap).
REQ-019 At window end in SETTLE: settle counter increments; after SETTLE_WIN windows go to RUN; dout, done, valid unchanged.
REQ-020 At window end in RUN: dout <= sat16((2*ones - DECIM) * 256); done=1 on the following cycle only; valid <= 1.
REQ-021 sat16 SHALL clamp to [-32768, 32767]; ones=DECIM yields 32767, ones=0 yields -32768, ones=DECIM/2 yields 0.
REQ-022 First done after enable SHALL occur (SETTLE_WIN+1)*DECIM edges after the IDLE->SETTLE edge (640 at defaults).
REQ-023 rd=1 with valid=1 and no simultaneous publish: valid <= 0.
REQ-024 Publish with rd=1 on the same edge: valid stays 1, overrun unchanged.
REQ-025 Publish with valid=1 and rd=0: overrun <= 1; dout overwritten with new sample.
REQ-026 rd while valid=0: ignored.
REQ-027 enable=0 in SETTLE or RUN: next state IDLE; partial window discarded; dout and valid retained; no done.
REQ-028 dout SHALL hold its value between publishes.

Reset
REQ-029 reset=1 SHALL, on the edge, set state IDLE, dout=0, done=0, valid=0, overrun=0, cnt=0, acc=0, settle counter=0, s=0; micLRSel=0 at all times.
REQ-030 reset SHALL take priority over enable, rd and window-end events, including mid-window.

Verification
REQ-031 enable=1, micData all ones -> first done at edge 640, dout=32767 (0x7FFF), valid=1.
REQ-032 micData all zeros -> dout=-32768 (0x8000); alternating 1/0 -> dout=0; 96 ones per 128-bit window -> dout=16384 (0x4000).
REQ-033 rd never asserted across two RUN windows -> overrun=1 after the second done; rd pulse clears valid; overrun stays 1 until re-enable or reset.
REQ-034 rd=1 on the same edge as a publish -> valid stays 1, overrun stays 0.
REQ-035 enable dropped 50 edges into a RUN window, re-raised -> no done for 640 edges after re-entry; dout keeps the prior sample meanwhile.
REQ-036 reset asserted mid-window in RUN -> all outputs 0 the next cycle; no done until 640 edges after the next IDLE->SETTLE edge.
